psx_port_serdes: RTL
====================

Name: psx_port_serdes

Overview:
- Physical-layer device port for the PSX controller bus, sitting directly upstream of the controller state machine.
- Synchronises PSX_sel, PSX_clk and PSX_cmd into the clk domain.
- Deserialises command bytes LSB-first, serialises reply bytes onto open-drain PSX_dat, and generates the post-byte PSX_ack pulse.
- Presents a byte-level strobe interface to the controller logic.

Parameters:
- CLOCK_MHZ, 25, system clock frequency in MHz; used for all microsecond timing.
- ACK_DELAY_US, 4, delay from byte completion (command_strobe) to ACK assertion.
- ACK_WIDTH_US, 2, duration PSX_ack is held low.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- PSX_ack  inout  1  open-drain acknowledge; driven 0 or Z, never 1
- PSX_clk  input  1  bus clock; idles high
- PSX_sel  input  1  attention/select, active low
- PSX_cmd  input  1  host-to-device data
- PSX_dat  inout  1  open-drain device-to-host data; driven 0 or Z
- packet_reset  output  1  one-cycle pulse on synchronised PSX_sel falling edge
- ack_enable  input  1  consumer requests ACK for the byte just received
- command  output  8  last complete received byte; held until the next strobe
- command_strobe  output  1  one-cycle pulse when command is valid
- reply  input  8  byte to transmit during the next bus byte
- reply_en  input  1  1 = drive reply onto PSX_dat; 0 = keep PSX_dat Hi-Z for that byte
- reply_ready  output  1  one-cycle pulse when reply/reply_en have been latched

Behaviour:
- Clock and reset:
  - clk is the system clock; reset is asynchronous and active-high.
  - Reset values: packet_reset=0, command_strobe=0, reply_ready=0, command=8'h00, PSX_ack=Z, PSX_dat=Z, state=IDLE, bit counter=0, ACK timer=0.
- Synchronisation and edge detection:
  - PSX_sel, PSX_clk and PSX_cmd each pass through a 2-FF synchroniser.
  - Edge detection is performed on the synchronised copies.
- States: IDLE, SHIFT, ACK_WAIT, ACK_DRIVE.
- IDLE (sel high):
  - On synchronised sel fall: pulse packet_reset, clear the bit counter, tx_en=0, go to SHIFT.
- SHIFT:
  - On each synchronised CLK falling edge with bit counter==0: latch reply into tx_shift and reply_en into tx_en, pulse reply_ready the same cycle, and present tx_shift[0] on DAT.
  - On later falling edges: shift tx_shift right and present the next bit.
  - On each synchronised CLK rising edge: shift synchronised CMD into rx_shift[7] (LSB-first) and increment the bit counter.
  - On the 8th rising edge: command<=completed byte, pulse command_strobe (3 clk after the pin edge), wrap the bit counter to 0, go to ACK_WAIT.
- DAT drive:
  - PSX_dat = 0 when sel_sync low, tx_en=1 and the current tx bit=0; otherwise Z.
- ACK_WAIT:
  - Sample ack_enable on the clk cycle after command_strobe, so the consumer has one cycle to update its state.
  - If ack_enable=0: return to SHIFT, no ACK.
  - If ack_enable=1: count CLOCK_MHZ*ACK_DELAY_US cycles from the strobe, then go to ACK_DRIVE.
- ACK_DRIVE:
  - PSX_ack=0 for CLOCK_MHZ*ACK_WIDTH_US cycles, then Z and return to SHIFT.
- Boundary conditions:
  - Sel rises at any time, including mid-byte or during ACK: release DAT and ACK immediately (same cycle as the synchronised edge), discard the partial byte, no command_strobe, go to IDLE.
  - CLK falling edge during ACK_WAIT/ACK_DRIVE: cancel ACK (release), go to SHIFT, and treat the edge as bit 0 of the next byte (latch reply).
  - Sel fall while not IDLE (glitch-free re-select without rise) cannot occur; the synchronised sel must rise first.
  - Timer width: clog2(CLOCK_MHZ*(ACK_DELAY_US+ACK_WIDTH_US))+1 bits; no wrap permitted.
  - reset asserted mid-byte: all outputs return to reset values asynchronously; the bus sees DAT/ACK released.

Decomposition:
- Shared package psx_port_pkg holds:
  - state encodings (IDLE=0, SHIFT=1, ACK_WAIT=2, ACK_DRIVE=3);
  - the PADDING_BYTE (8'h5A) constant;
  - a function computing cycle counts from CLOCK_MHZ and microsecond values.
- One sub-module: psx_sync_edge.
  - 2-FF synchroniser plus registered rise/fall pulse outputs.
  - Instantiated for PSX_sel and PSX_clk; PSX_cmd uses a plain 2-FF synchroniser.

Test Plan:
- Sel falls, host shifts 8'h01 with reply_en=0 and ack_enable=1 -> packet_reset pulse, PSX_dat stays Z for all 8 bits, command=8'h01 strobed once, PSX_ack low starting 100 clk after the strobe for 50 clk (25 MHz).
- Second byte 8'h42 with reply=8'h73, reply_en=1 -> host samples 0x73 LSB-first on rising edges, reply_ready pulses once at the first falling edge, command=8'h42.
- ack_enable=0 the cycle after strobe -> PSX_ack never leaves Z; the next byte still receives correctly.
- Sel rises after 5 bits -> no command_strobe, DAT/ACK Z within 3 clk, next packet starts with packet_reset and a correct byte.
- Host starts the next byte's falling CLK during ACK_DRIVE -> ACK released the same cycle, reply latched, byte received correctly.
- reset asserted mid-byte with DAT driven low -> DAT Z immediately, outputs at reset values, a subsequent packet works.

Source files
------------

// File: rtl/psx_port_pkg.sv
// Shared types and constants for the PSX controller-bus device port.
package psx_port_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHIFT     = 2'd1,
      ACK_WAIT  = 2'd2,
      ACK_DRIVE = 2'd3
   } psx_state_e;

   localparam logic [7:0] PADDING_BYTE = 8'h5A;

   function automatic int unsigned us_to_cycles(input int unsigned clock_mhz,
                                                input int unsigned us);
      return clock_mhz * us;
   endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses aligned to the synchronised output.
module psx_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, rise_q, fall_q;

   // Pulses are computed from s1/s2 so they assert in the same cycle sync_o changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q   <= RESET_VAL;
         s2_q   <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         rise_q <= s1_q & ~s2_q;
         fall_q <= ~s1_q & s2_q;
      end
   end

   assign sync_o = s2_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/psx_port_serdes.sv
// PSX bus device port: synchronises the bus, shifts command/reply bytes and times the ACK pulse.
module psx_port_serdes
   import psx_port_pkg::*;
#(
   parameter int unsigned CLOCK_MHZ    = 25,
   parameter int unsigned ACK_DELAY_US = 4,
   parameter int unsigned ACK_WIDTH_US = 2
) (
   input  logic       clk,
   input  logic       reset,
   inout  logic       PSX_ack,
   input  logic       PSX_clk,
   input  logic       PSX_sel,
   input  logic       PSX_cmd,
   inout  logic       PSX_dat,
   output logic       packet_reset,
   input  logic       ack_enable,
   output logic [7:0] command,
   output logic       command_strobe,
   input  logic [7:0] reply,
   input  logic       reply_en,
   output logic       reply_ready
);

   localparam int unsigned DELAY_CYC = us_to_cycles(CLOCK_MHZ, ACK_DELAY_US);
   localparam int unsigned TOTAL_CYC = us_to_cycles(CLOCK_MHZ, ACK_DELAY_US + ACK_WIDTH_US);
   localparam int unsigned TW        = $clog2(TOTAL_CYC) + 1;
   localparam logic [TW-1:0] DELAY_LAST = TW'(DELAY_CYC - 1);
   localparam logic [TW-1:0] TOTAL_LAST = TW'(TOTAL_CYC - 1);

   logic sel_sync, sel_rise, sel_fall;
   logic clk_sync, clk_rise, clk_fall;
   logic cmd_s1_q, cmd_s2_q;

   psx_sync_edge #(.RESET_VAL(1'b1)) u_sel_sync (
      .clk(clk), .reset(reset), .d_i(PSX_sel),
      .sync_o(sel_sync), .rise_o(sel_rise), .fall_o(sel_fall)
   );

   psx_sync_edge #(.RESET_VAL(1'b1)) u_clk_sync (
      .clk(clk), .reset(reset), .d_i(PSX_clk),
      .sync_o(clk_sync), .rise_o(clk_rise), .fall_o(clk_fall)
   );

   psx_state_e    state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    rx_q, rx_d, tx_q, tx_d, command_q, command_d;
   logic          tx_en_q, tx_en_d;
   logic          strobe_q, strobe_d, prst_q, prst_d, rr_q, rr_d;
   logic          dat_drv, ack_drv;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_s1_q  <= 1'b0;
         cmd_s2_q  <= 1'b0;
         state_q   <= IDLE;
         bitcnt_q  <= '0;
         timer_q   <= '0;
         rx_q      <= '0;
         tx_q      <= PADDING_BYTE;
         tx_en_q   <= 1'b0;
         command_q <= '0;
         strobe_q  <= 1'b0;
         prst_q    <= 1'b0;
         rr_q      <= 1'b0;
      end else begin
         cmd_s1_q  <= PSX_cmd;
         cmd_s2_q  <= cmd_s1_q;
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         timer_q   <= timer_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         tx_en_q   <= tx_en_d;
         command_q <= command_d;
         strobe_q  <= strobe_d;
         prst_q    <= prst_d;
         rr_q      <= rr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      timer_d   = timer_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      tx_en_d   = tx_en_q;
      command_d = command_q;
      strobe_d  = 1'b0;
      prst_d    = 1'b0;
      rr_d      = 1'b0;
      if (state_q == IDLE) begin
         if (sel_fall) begin
            prst_d   = 1'b1;
            bitcnt_d = '0;
            tx_en_d  = 1'b0;
            state_d  = SHIFT;
         end
      end else if (sel_rise) begin
         state_d  = IDLE;
         bitcnt_d = '0;
         timer_d  = '0;
         tx_en_d  = 1'b0;
         tx_d     = PADDING_BYTE;
      end else begin
         // A falling bus clock in either ACK state aborts the ACK and starts the next byte.
         if (clk_fall) begin
            if (bitcnt_q == 3'd0) begin
               tx_d    = reply;
               tx_en_d = reply_en;
               rr_d    = 1'b1;
            end else begin
               tx_d = {1'b0, tx_q[7:1]};
            end
            if (state_q != SHIFT) begin
               state_d = SHIFT;
               timer_d = '0;
            end
         end
         case (state_q)
            SHIFT: begin
               if (clk_rise) begin
                  rx_d     = {cmd_s2_q, rx_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'd7) begin
                     command_d = rx_d;
                     strobe_d  = 1'b1;
                     state_d   = ACK_WAIT;
                     timer_d   = '0;
                  end
               end
            end
            ACK_WAIT: begin
               if (!clk_fall) begin
                  timer_d = timer_q + TW'(1);
                  if (timer_q == TW'(1) && !ack_enable) begin
                     state_d = SHIFT;
                     timer_d = '0;
                  end else if (timer_q == DELAY_LAST) begin
                     state_d = ACK_DRIVE;
                  end
               end
            end
            ACK_DRIVE: begin
               if (!clk_fall) begin
                  timer_d = timer_q + TW'(1);
                  if (timer_q == TOTAL_LAST) begin
                     state_d = SHIFT;
                     timer_d = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Gating on the synchronised levels releases the bus in the same cycle the edge is seen.
   always_comb begin
      dat_drv = 1'b0;
      ack_drv = 1'b0;
      if (!sel_sync && tx_en_q && !tx_q[0]) dat_drv = 1'b1;
      if (state_q == ACK_DRIVE && !sel_sync && clk_sync) ack_drv = 1'b1;
   end

   assign PSX_dat        = dat_drv ? 1'b0 : 1'bz;
   assign PSX_ack        = ack_drv ? 1'b0 : 1'bz;
   assign command        = command_q;
   assign command_strobe = strobe_q;
   assign packet_reset   = prst_q;
   assign reply_ready    = rr_q;

endmodule
